// File: rtl/divu_seq_ctrl.sv
// Multi-cycle unsigned divide sequencer for the EX stage: freezes the pipeline front,
// runs a 1-bit-per-cycle restoring division and publishes quotient/remainder to LO/HI.
//
// state | meaning
// IDLE  | waiting for a divu in EX; decodes stall combinationally from op_valid
// RUN   | one restoring step per cycle, pipeline front held
// DONE  | HI/LO/div_by_zero written at the closing edge; pipeline released
module divu_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic             flush,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             div_by_zero
);

  localparam int CW = $clog2(ITER + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;
  logic             zero_path;

  logic             in_idle;
  logic             in_run;
  logic             in_done;
  logic             start;
  logic             divisor_zero;
  logic             last_step;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;
  logic             ge;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic             unused_diff_bit;

  assign in_idle      = (state == IDLE);
  assign in_run       = (state == RUN);
  assign in_done      = (state == DONE);
  assign start        = in_idle & op_valid & ~flush;
  assign divisor_zero = (divisor == '0);
  assign last_step    = (cnt == CW'(ITER - 1));

  // Restoring step: the shifted partial remainder can need WIDTH+1 bits, and the
  // extra top bit of the difference is the borrow that says "does not fit".
  assign rem_sh   = {rem, quo[WIDTH-1]};
  assign diff     = {1'b0, rem_sh} - {2'b00, dvsr};
  assign ge       = ~diff[WIDTH+1];
  assign rem_step = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_step = {quo[WIDTH-2:0], ge};

  // When ge holds the difference is below the divisor, so this bit is always zero.
  assign unused_diff_bit = diff[WIDTH];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = divisor_zero ? DONE : RUN;
        end
      end
      RUN: begin
        if (flush) begin
          state_nxt = IDLE;
        end else if (last_step) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == RUN);
    end
  end

  // The zero path parks all-ones/dividend in the working registers so DONE
  // publishes both outcomes through the same write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      rem       <= '0;
      quo       <= '0;
      dvsr      <= '0;
      zero_path <= 1'b0;
    end else if (start) begin
      cnt       <= '0;
      zero_path <= divisor_zero;
      if (divisor_zero) begin
        quo <= '1;
        rem <= dividend;
      end else begin
        quo  <= dividend;
        rem  <= '0;
        dvsr <= divisor;
      end
    end else if (in_run && !flush) begin
      rem <= rem_step;
      quo <= quo_step;
      cnt <= cnt + 1'b1;
    end
  end

  // A flush during DONE does not cancel this write; the result is already committed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lo          <= '0;
      hi          <= '0;
      div_by_zero <= 1'b0;
    end else if (in_done) begin
      lo          <= quo;
      hi          <= rem;
      div_by_zero <= zero_path;
    end
  end

  assign done  = in_done;
  assign stall = rst & (start | in_run);

endmodule

// File: tb/tb_divu_seq_ctrl.sv
// Self-checking bench for divu_seq_ctrl: directed cases from the pipeline use model
// plus randomized divides checked against plain-arithmetic reference results.
module tb_divu_seq_ctrl;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         op_valid;
  logic         flush;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         stall;
  logic         busy;
  logic         done;
  logic [W-1:0] lo;
  logic [W-1:0] hi;
  logic         div_by_zero;

  int n_chk  = 0;
  int n_fail = 0;

  divu_seq_ctrl #(.WIDTH(W), .ITER(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .op_valid    (op_valid),
    .flush       (flush),
    .dividend    (dividend),
    .divisor     (divisor),
    .stall       (stall),
    .busy        (busy),
    .done        (done),
    .lo          (lo),
    .hi          (hi),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Presents one divu at the current negedge and keeps it in EX (op_valid held)
  // until done, as the stalled pipeline would. Operand buses wander after cycle 0
  // to confirm the divider uses only what it captured. Returns one cycle after
  // done with op_valid low and results checked.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit fl_done);
    logic [W-1:0] e_lo;
    logic [W-1:0] e_hi;
    bit           e_dz;
    int           e_cyc;
    int           n_stall;
    int           done_cyc;
    bit           seen;
    e_dz     = (b == 0);
    e_lo     = e_dz ? {W{1'b1}} : a / b;
    e_hi     = e_dz ? a : a % b;
    e_cyc    = e_dz ? 1 : W + 1;
    n_stall  = 0;
    done_cyc = -1;
    seen     = 1'b0;
    op_valid = 1'b1;
    dividend = a;
    divisor  = b;
    for (int c = 0; c < 45 && !seen; c++) begin
      if (c > 0) begin
        @(negedge clk);
        dividend = $urandom;
        divisor  = $urandom;
      end
      #1;
      if (stall) n_stall++;
      chk("busy", busy, (!e_dz && c >= 1 && c <= W));
      if (done) begin
        seen     = 1'b1;
        done_cyc = c;
        if (fl_done) flush = 1'b1;
      end
    end
    chk("done_seen", seen, 1'b1);
    chk("done_cycle", done_cyc, e_cyc);
    chk("stall_cycles", n_stall, e_cyc);
    @(negedge clk);
    op_valid = 1'b0;
    flush    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    #1;
    chk("lo", lo, e_lo);
    chk("hi", hi, e_hi);
    chk("div_by_zero", div_by_zero, e_dz);
    chk("done_after", done, 1'b0);
    chk("stall_after", stall, 1'b0);
  endtask

  task automatic step_to_next_cycle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int           n_done;

    rst      = 1'b0;
    op_valid = 1'b0;
    flush    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_lo", lo, 0);
    chk("rst_hi", hi, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", div_by_zero, 0);
    op_valid = 1'b1;
    #1;
    chk("rst_stall", stall, 0);
    op_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_div(32'd100, 32'd7, 1'b0);
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_div(32'd5, 32'd0, 1'b0);
    run_div(32'd9, 32'd3, 1'b0);
    run_div(32'd100, 32'd7, 1'b0);

    // Flush at cycle 10 of a running divide: no done, prior results kept.
    op_valid = 1'b1;
    dividend = 32'd50;
    divisor  = 32'd3;
    #1;
    chk("fl_stall", stall, 1);
    for (int c = 1; c <= 10; c++) begin
      step_to_next_cycle();
      chk("fl_stall", stall, 1);
      chk("fl_done", done, 0);
    end
    flush = 1'b1;
    #1;
    chk("fl_stall_same", stall, 1);
    step_to_next_cycle();
    op_valid = 1'b0;
    flush    = 1'b0;
    #1;
    chk("fl_stall_drop", stall, 0);
    chk("fl_busy_drop", busy, 0);
    n_done = 0;
    for (int c = 0; c < 40; c++) begin
      step_to_next_cycle();
      if (done) n_done++;
    end
    chk("fl_no_done", n_done, 0);
    chk("fl_lo", lo, 14);
    chk("fl_hi", hi, 2);
    chk("fl_dbz", div_by_zero, 0);

    // Flush together with op_valid in IDLE: nothing starts.
    op_valid = 1'b1;
    flush    = 1'b1;
    dividend = 32'd77;
    divisor  = 32'd0;
    #1;
    chk("fl_idle_stall", stall, 0);
    step_to_next_cycle();
    chk("fl_idle_done", done, 0);
    chk("fl_idle_busy", busy, 0);
    op_valid = 1'b0;
    flush    = 1'b0;
    step_to_next_cycle();
    chk("fl_idle_lo", lo, 14);

    // Reset asserted at cycle 12 of a running divide.
    op_valid = 1'b1;
    dividend = 32'd100;
    divisor  = 32'd7;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
    end
    #1;
    chk("rr_busy_before", busy, 1);
    rst = 1'b0;
    #1;
    chk("rr_stall", stall, 0);
    chk("rr_busy", busy, 0);
    chk("rr_hi", hi, 0);
    chk("rr_lo", lo, 0);
    chk("rr_done", done, 0);
    chk("rr_dbz", div_by_zero, 0);
    @(negedge clk);
    op_valid = 1'b0;
    rst      = 1'b1;
    step_to_next_cycle();
    chk("rr_idle_stall", stall, 0);
    chk("rr_idle_busy", busy, 0);
    chk("rr_idle_done", done, 0);
    run_div(32'd1000, 32'd10, 1'b0);

    // Back-to-back divides, then a flush landing on DONE.
    run_div(32'd20, 32'd6, 1'b0);
    run_div(32'd7, 32'd7, 1'b0);
    run_div(32'd123456, 32'd789, 1'b1);
    run_div(32'd42, 32'd0, 1'b1);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'd1;
        2:       rb = $urandom_range(2, 15);
        3:       rb = ra;
        4:       rb = $urandom;
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      run_div(ra, rb, ($urandom_range(0, 5) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
